// File: rtl/seq_add_sub_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_add_sub_if
// Purpose  : Operand/result valid-ready bundle for the sequential add/sub unit
// Revision : 1.0
// ============================================================================
interface seq_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co, ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_add_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_add_sub
// Purpose  : Multi-cycle adder/subtractor, CHUNK bits per cycle, LSB first
// Revision : 1.0
// ============================================================================
module seq_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst,
    seq_add_sub_if.slave      bus_io
);
    localparam int NCH   = WIDTH / CHUNK;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NCH - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
            $fatal(1, "seq_add_sub: CHUNK must satisfy 1 <= CHUNK <= WIDTH");
        end else if (WIDTH % CHUNK != 0) begin : g_bad_width
            $fatal(1, "seq_add_sub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ra_q, ra_d;
    logic [WIDTH-1:0]   rb_q, rb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               carry_q, carry_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [CHUNK:0]     chunk_sum;
    logic               chunk_msb_cin;
    logic [WIDTH-1:0]   res_ins;
    logic               in_ready, out_valid, busy;

    assign chunk_sum = {1'b0, ra_q[CHUNK-1:0]} + {1'b0, rb_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk MSB recovered from its sum bit; in the last chunk this is the carry into bit WIDTH-1.
    assign chunk_msb_cin = chunk_sum[CHUNK-1] ^ ra_q[CHUNK-1] ^ rb_q[CHUNK-1];

    always_comb begin
        res_ins = res_q;
        res_ins[cnt_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            res_q   <= res_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        res_d     = res_q;
        s_d       = s_q;
        carry_d   = carry_q;
        co_d      = co_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus_io.in_valid) begin
                    // Subtraction is a + ~b + ~borrow, so the RUN datapath only ever adds.
                    ra_d    = bus_io.a;
                    rb_d    = bus_io.sub ? ~bus_io.b : bus_io.b;
                    carry_d = bus_io.sub ? ~bus_io.ci : bus_io.ci;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                ra_d    = ra_q >> CHUNK;
                rb_d    = rb_q >> CHUNK;
                carry_d = chunk_sum[CHUNK];
                res_d   = res_ins;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    cnt_d   = '0;
                    s_d     = res_ins;
                    co_d    = chunk_sum[CHUNK];
                    ovf_d   = chunk_msb_cin ^ chunk_sum[CHUNK];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus_io.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.out_valid = out_valid;
    assign bus_io.busy      = busy;
    assign bus_io.s         = s_q;
    assign bus_io.co        = co_q;
    assign bus_io.ovf       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_add_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_add_sub
// Purpose  : Directed checks of seq_add_sub plus a CHUNK/WIDTH parameter sweep
// Revision : 1.0
// ============================================================================
module tb_seq_add_sub;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seq_add_sub_if #(.WIDTH(16)) m_if ();
    seq_add_sub #(.WIDTH(16), .CHUNK(4)) u_dut (.clk(clk), .rst(rst), .bus_io(m_if));

    // Sweep instances share one stimulus source.
    logic        sw_valid, sw_ci, sw_sub;
    logic [15:0] sw_a, sw_b;

    seq_add_sub_if #(.WIDTH(16)) c16_if ();
    seq_add_sub_if #(.WIDTH(16)) c1_if ();
    seq_add_sub_if #(.WIDTH(16)) c8_if ();
    seq_add_sub_if #(.WIDTH(4))  w4_if ();

    seq_add_sub #(.WIDTH(16), .CHUNK(16)) u_c16 (.clk(clk), .rst(rst), .bus_io(c16_if));
    seq_add_sub #(.WIDTH(16), .CHUNK(1))  u_c1  (.clk(clk), .rst(rst), .bus_io(c1_if));
    seq_add_sub #(.WIDTH(16), .CHUNK(8))  u_c8  (.clk(clk), .rst(rst), .bus_io(c8_if));
    seq_add_sub #(.WIDTH(4),  .CHUNK(1))  u_w4  (.clk(clk), .rst(rst), .bus_io(w4_if));

    assign c16_if.in_valid = sw_valid, c16_if.a = sw_a, c16_if.b = sw_b;
    assign c16_if.ci = sw_ci, c16_if.sub = sw_sub, c16_if.out_ready = 1'b1;
    assign c1_if.in_valid = sw_valid, c1_if.a = sw_a, c1_if.b = sw_b;
    assign c1_if.ci = sw_ci, c1_if.sub = sw_sub, c1_if.out_ready = 1'b1;
    assign c8_if.in_valid = sw_valid, c8_if.a = sw_a, c8_if.b = sw_b;
    assign c8_if.ci = sw_ci, c8_if.sub = sw_sub, c8_if.out_ready = 1'b1;
    assign w4_if.in_valid = sw_valid, w4_if.a = sw_a[3:0], w4_if.b = sw_b[3:0];
    assign w4_if.ci = sw_ci, w4_if.sub = sw_sub, w4_if.out_ready = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {ovf, co, s} from a full-width sum and the sign rule.
    function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sub);
        logic [15:0] rb;
        logic [16:0] f;
        logic        ov;
        rb = sub ? ~b : b;
        f  = {1'b0, a} + {1'b0, rb} + {16'd0, (sub ? ~ci : ci)};
        ov = (a[15] == rb[15]) && (f[15] != a[15]);
        return {ov, f[16], f[15:0]};
    endfunction

    function automatic logic [5:0] ref4(input logic [3:0] a, input logic [3:0] b,
                                        input logic ci, input logic sub);
        logic [3:0] rb;
        logic [4:0] f;
        logic       ov;
        rb = sub ? ~b : b;
        f  = {1'b0, a} + {1'b0, rb} + {4'd0, (sub ? ~ci : ci)};
        ov = (a[3] == rb[3]) && (f[3] != a[3]);
        return {ov, f[4], f[3:0]};
    endfunction

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sub,
                          input logic [15:0] es, input logic eco, input logic eovf);
        int cyc;
        m_if.a = a; m_if.b = b; m_if.ci = ci; m_if.sub = sub;
        m_if.in_valid = 1'b1; m_if.out_ready = 1'b1;
        check({tag, " in_ready"}, m_if.in_ready, 1);
        tick();
        m_if.in_valid = 1'b0;
        m_if.a = ~a; m_if.b = ~b; m_if.ci = ~ci; m_if.sub = ~sub;
        cyc = 0;
        while (m_if.out_valid !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, 4);
        check({tag, " s"}, m_if.s, es);
        check({tag, " co"}, m_if.co, eco);
        check({tag, " ovf"}, m_if.ovf, eovf);
        tick();
        check({tag, " idle out_valid"}, m_if.out_valid, 0);
        check({tag, " idle in_ready"}, m_if.in_ready, 1);
    endtask

    task automatic sweep_op(input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic sub);
        int          lat [4];
        logic [15:0] rs  [4];
        logic        rco [4];
        logic        rov [4];
        int          want [4];
        logic [17:0] e16;
        logic [5:0]  e4;
        want = '{1, 16, 2, 4};
        for (int i = 0; i < 4; i++) lat[i] = -1;
        sw_a = a; sw_b = b; sw_ci = ci; sw_sub = sub; sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0; sw_a = ~a; sw_b = ~b; sw_ci = ~ci; sw_sub = ~sub;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c16_if.out_valid && lat[0] < 0) begin lat[0] = c; rs[0] = c16_if.s; rco[0] = c16_if.co; rov[0] = c16_if.ovf; end
            if (c1_if.out_valid  && lat[1] < 0) begin lat[1] = c; rs[1] = c1_if.s;  rco[1] = c1_if.co;  rov[1] = c1_if.ovf;  end
            if (c8_if.out_valid  && lat[2] < 0) begin lat[2] = c; rs[2] = c8_if.s;  rco[2] = c8_if.co;  rov[2] = c8_if.ovf;  end
            if (w4_if.out_valid  && lat[3] < 0) begin lat[3] = c; rs[3] = {12'd0, w4_if.s}; rco[3] = w4_if.co; rov[3] = w4_if.ovf; end
        end
        e16 = ref16(a, b, ci, sub);
        e4  = ref4(a[3:0], b[3:0], ci, sub);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sweep%0d a=%h b=%h latency", i, a, b), lat[i], want[i]);
            check($sformatf("sweep%0d a=%h b=%h s", i, a, b), rs[i],
                  (i == 3) ? {12'd0, e4[3:0]} : e16[15:0]);
            check($sformatf("sweep%0d a=%h b=%h co", i, a, b), rco[i], (i == 3) ? e4[4] : e16[16]);
            check($sformatf("sweep%0d a=%h b=%h ovf", i, a, b), rov[i], (i == 3) ? e4[5] : e16[17]);
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        m_if.in_valid = 1'b0; m_if.out_ready = 1'b0;
        m_if.a = '0; m_if.b = '0; m_if.ci = 1'b0; m_if.sub = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0;
        #1;
        check("reset in_ready", m_if.in_ready, 1);
        check("reset out_valid", m_if.out_valid, 0);
        check("reset busy", m_if.busy, 0);
        check("reset s", m_if.s, 0);
        check("reset co", m_if.co, 0);
        check("reset ovf", m_if.ovf, 0);
        tick();
        tick();
        rst = 1'b0;

        run_op("add 2+1",       16'h0002, 16'h0001, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        run_op("add FFFF+1",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add 7FFF+1",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub 5-7",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub 8000-1",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Abort after two of four chunk edges.
        m_if.a = 16'h00FF; m_if.b = 16'h0F0F; m_if.ci = 1'b0; m_if.sub = 1'b0;
        m_if.in_valid = 1'b1; m_if.out_ready = 1'b1;
        tick();
        m_if.in_valid = 1'b0;
        tick();
        tick();
        check("midrun busy before reset", m_if.busy, 1);
        rst = 1'b1;
        #1;
        check("midrun reset out_valid", m_if.out_valid, 0);
        check("midrun reset s", m_if.s, 0);
        check("midrun reset co", m_if.co, 0);
        check("midrun reset ovf", m_if.ovf, 0);
        check("midrun reset in_ready", m_if.in_ready, 1);
        check("midrun reset busy", m_if.busy, 0);
        tick();
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_if.out_valid) cyc++;
        end
        check("midrun no out_valid pulse", cyc, 0);

        run_op("add 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("sub 5-2-1",     16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

        // Backpressure: hold DONE while in_valid toggles.
        m_if.a = 16'h1111; m_if.b = 16'h2222; m_if.ci = 1'b0; m_if.sub = 1'b0;
        m_if.in_valid = 1'b1; m_if.out_ready = 1'b0;
        tick();
        m_if.in_valid = 1'b0;
        cyc = 0;
        while (m_if.out_valid !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("bp latency", cyc, 4);
        for (int i = 0; i < 5; i++) begin
            m_if.in_valid = i[0];
            m_if.a = 16'hAAAA; m_if.b = 16'h5555;
            tick();
            check($sformatf("bp hold%0d out_valid", i), m_if.out_valid, 1);
            check($sformatf("bp hold%0d s", i), m_if.s, 16'h3333);
            check($sformatf("bp hold%0d co", i), m_if.co, 0);
            check($sformatf("bp hold%0d ovf", i), m_if.ovf, 0);
            check($sformatf("bp hold%0d in_ready", i), m_if.in_ready, 0);
            check($sformatf("bp hold%0d busy", i), m_if.busy, 1);
        end
        m_if.in_valid = 1'b0;
        m_if.out_ready = 1'b1;
        tick();
        check("bp release out_valid", m_if.out_valid, 0);
        check("bp release in_ready", m_if.in_ready, 1);
        check("bp release busy", m_if.busy, 0);
        check("bp release s held", m_if.s, 16'h3333);
        run_op("bp next op",    16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);

        // Reset and in_valid on the same edge: nothing accepted.
        m_if.a = 16'h0001; m_if.b = 16'h0001;
        m_if.in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_if.in_valid = 1'b0;
        tick();
        check("same-edge reset busy", m_if.busy, 0);
        check("same-edge reset in_ready", m_if.in_ready, 1);
        check("same-edge reset s", m_if.s, 0);

        sweep_op(16'h0002, 16'h0001, 1'b0, 1'b0);
        sweep_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        sweep_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            sweep_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
